imem_dmem_arbiter: RTL and testbench
====================================

Name: imem_dmem_arbiter

Overview:
- Main-memory side of the cache hierarchy; sits directly upstream of the fetch stage's instruction cache and services its line-refill requests.
- Also services the data cache, arbitrating both onto a single fixed-latency line memory.
- Transfers 128-bit lines addressed by 26-bit line addresses.
- Serves one transaction at a time with a registered response/ack handshake.

Parameters:
- LATENCY, 5, number of BUSY cycles between grant and response; legal range 1..255.
- DEPTH_LOG2, 10, log2 of line-array entries; array indexed by reqAddr[DEPTH_LOG2-1:0], upper address bits ignored.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- reqI_mem  in  1  icache line-read request (level, held until read_ready_I seen)
- reqAddrI_mem  in  26  icache line address
- instr_from_mem  out  128  line returned to icache
- read_ready_I  out  1  one-cycle pulse: instr_from_mem valid
- written_data_ack_I  out  1  one-cycle pulse in the cycle after the icache request is granted
- reqD_mem  in  1  dcache request (level)
- reqD_write  in  1  1 = line write, 0 = line read; sampled at grant
- reqAddrD_mem  in  26  dcache line address
- reqD_wdata  in  128  write line; sampled at grant
- data_from_mem  out  128  line returned to dcache
- read_ready_D  out  1  one-cycle pulse: data_from_mem valid (reads only)
- written_data_ack_D  out  1  one-cycle pulse: dcache write committed
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset is asynchronous and active-low.
  - While reset is low: state = IDLE, counter = 0, all outputs 0.
  - Line-array contents are not altered by reset; simulation initialises them to 0.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - If either request is high at a clock edge, grant it.
  - At the grant, latch the requester ID, address, write flag and write data; load counter with LATENCY-1; go to BUSY.
  - Fixed priority: D over I.
  - An icache grant pulses written_data_ack_I in the following cycle.
- BUSY:
  - Decrement the counter each cycle.
  - When the counter = 0, perform the array access on that edge: read the latched index, or write the latched data. Then go to RESP.
  - New requests are ignored while in BUSY.
- RESP (exactly one cycle):
  - Pulse the ready/ack output for the served requester.
  - Read data on instr_from_mem/data_from_mem is valid during RESP and held until the next read response to that same port.
  - Next state is IDLE.
- Timing: request high in cycle 0, grant at end of cycle 0, BUSY occupies cycles 1..LATENCY, RESP in cycle LATENCY+1. Back-to-back transactions are therefore separated by at least one IDLE cycle.
- Requesters deassert req on the edge at which they sample their ready pulse. A req still high in IDLE is treated as a new request.
- Write then read of the same index returns the written line: the write commits before RESP.
- Reset asserted mid-transaction: abort, no pulse issued, a pending write is not performed if the commit edge has not occurred.
- A requester that drops req while in BUSY is still answered; the pulse is ignored.

Optional Feature:
- Macro: IMEM_DMEM_ARB_RR_EN.
- Defined: round-robin arbitration. A last-grant flag (reset value I) gives priority to the requester not served last when both are pending.
- Undefined: fixed D-over-I priority, and the flag logic is absent.

Decomposition:
- Package mem_arb_pkg holds:
  - LINE_W = 128 and LADDR_W = 26
  - state enum {IDLE, BUSY, RESP}
  - requester enum {REQ_I, REQ_D}
- Sub-module mem_line_array is the synchronous single-port storage: clk, we, index, wdata, rdata registered on the access edge.
- Arbiter FSM, counter and output registers stay in the top module.

Test Plan:
- Reset then I read of addr 0x0000010, LATENCY=5 -> written_data_ack_I in cycle 1; read_ready_I in cycle 6 only; instr_from_mem = preloaded line 0x10.
- D write 0xDEADBEEF_00000000_CAFEF00D_12345678 to 0x0000003, then D read of 0x0000003 -> written_data_ack_D pulse once; read returns the same 128 bits; read_ready_D one cycle.
- reqI and reqD raised in the same cycle, fixed priority -> D served first; I granted in the first IDLE after D's RESP.
- Same as the previous case with IMEM_DMEM_ARB_RR_EN, both held continuously for 4 transactions -> grant order I, D, I, D.
- reset driven low in BUSY cycle 3 of a D write to 0x0000005 -> no ack; array[5] unchanged; all outputs 0 immediately (asynchronous).
- LATENCY=1, I read -> read_ready_I in cycle 2; busy high in cycles 1-2; req ignored during BUSY.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared widths and enums for the instruction/data line-memory arbiter.
package mem_arb_pkg;

  localparam int LINE_W  = 128;
  localparam int LADDR_W = 26;
  localparam int CNT_W   = 8;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  typedef enum logic {REQ_I, REQ_D} requester_t;

endpackage

// File: rtl/mem_line_array.sv
// Synchronous single-port line storage; rdata is registered on every edge from the presented index.
module mem_line_array
  import mem_arb_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] index,
  input  logic [LINE_W-1:0]     wdata,
  output logic [LINE_W-1:0]     rdata
);

  logic [LINE_W-1:0] mem [2**DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (we) mem[index] <= wdata;
    rdata <= mem[index];
  end

endmodule

// File: rtl/imem_dmem_arbiter.sv
// Arbitrates icache refills and dcache reads/writes onto one fixed-latency line memory.
// Define IMEM_DMEM_ARB_RR_EN for round-robin arbitration; default is fixed D-over-I priority.
module imem_dmem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int LATENCY    = 5,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               reqI_mem,
  input  logic [LADDR_W-1:0] reqAddrI_mem,
  output logic [LINE_W-1:0]  instr_from_mem,
  output logic               read_ready_I,
  output logic               written_data_ack_I,
  input  logic               reqD_mem,
  input  logic               reqD_write,
  input  logic [LADDR_W-1:0] reqAddrD_mem,
  input  logic [LINE_W-1:0]  reqD_wdata,
  output logic [LINE_W-1:0]  data_from_mem,
  output logic               read_ready_D,
  output logic               written_data_ack_D,
  output logic               busy
);

  state_t                  state;
  requester_t              grant_id;
  logic [CNT_W-1:0]        count;
  logic [DEPTH_LOG2-1:0]   lat_index;
  logic                    lat_write;
  logic [LINE_W-1:0]       lat_wdata;
  logic [LINE_W-1:0]       rdata;
  logic [LINE_W-1:0]       instr_hold;
  logic [LINE_W-1:0]       data_hold;
  logic                    grant_d;
  logic                    array_we;
  logic                    unused_addr;

  assign unused_addr = ^{reqAddrI_mem, reqAddrD_mem};

`ifdef IMEM_DMEM_ARB_RR_EN
  requester_t last_grant;

  // On contention the requester not served last wins; reset value REQ_I favours D first.
  always_comb begin
    grant_d = reqD_mem;
    if (reqD_mem && reqI_mem) grant_d = (last_grant == REQ_I);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant <= REQ_I;
    end else if (state == IDLE && (reqD_mem || reqI_mem)) begin
      last_grant <= grant_d ? REQ_D : REQ_I;
    end
  end
`else
  always_comb begin
    grant_d = reqD_mem;
  end
`endif

  assign array_we = (state == BUSY) && (count == '0) && lat_write;

  mem_line_array #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_array (
    .clk  (clk),
    .we   (array_we),
    .index(lat_index),
    .wdata(lat_wdata),
    .rdata(rdata)
  );

  // The array result lands on the edge entering RESP, so it is forwarded for that cycle and held afterwards.
  assign instr_from_mem = read_ready_I ? rdata : instr_hold;
  assign data_from_mem  = read_ready_D ? rdata : data_hold;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state              <= IDLE;
      grant_id           <= REQ_I;
      count              <= '0;
      lat_index          <= '0;
      lat_write          <= 1'b0;
      lat_wdata          <= '0;
      instr_hold         <= '0;
      data_hold          <= '0;
      read_ready_I       <= 1'b0;
      read_ready_D       <= 1'b0;
      written_data_ack_I <= 1'b0;
      written_data_ack_D <= 1'b0;
      busy               <= 1'b0;
    end else begin
      read_ready_I       <= 1'b0;
      read_ready_D       <= 1'b0;
      written_data_ack_I <= 1'b0;
      written_data_ack_D <= 1'b0;
      case (state)
        IDLE: begin
          if (reqD_mem || reqI_mem) begin
            grant_id           <= grant_d ? REQ_D : REQ_I;
            lat_index          <= grant_d ? reqAddrD_mem[DEPTH_LOG2-1:0]
                                          : reqAddrI_mem[DEPTH_LOG2-1:0];
            lat_write          <= grant_d && reqD_write;
            lat_wdata          <= reqD_wdata;
            count              <= CNT_W'(LATENCY - 1);
            written_data_ack_I <= !grant_d;
            busy               <= 1'b1;
            state              <= BUSY;
          end
        end
        BUSY: begin
          if (count == '0) begin
            state <= RESP;
            if (grant_id == REQ_I)  read_ready_I       <= 1'b1;
            else if (lat_write)     written_data_ack_D <= 1'b1;
            else                    read_ready_D       <= 1'b1;
          end else begin
            count <= count - 1'b1;
          end
        end
        RESP: begin
          if (grant_id == REQ_I)  instr_hold <= rdata;
          else if (!lat_write)    data_hold  <= rdata;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Scoreboard bench for imem_dmem_arbiter; honours IMEM_DMEM_ARB_RR_EN for the contention scenario.
module tb_imem_dmem_arbiter;

  localparam int LAT = 5;

  typedef struct {
    bit           is_d;
    bit           wr;
    logic [127:0] data;
  } exp_t;

  logic         clk;
  logic         reset;
  logic         reqI_mem;
  logic [25:0]  reqAddrI_mem;
  logic [127:0] instr_from_mem;
  logic         read_ready_I;
  logic         written_data_ack_I;
  logic         reqD_mem;
  logic         reqD_write;
  logic [25:0]  reqAddrD_mem;
  logic [127:0] reqD_wdata;
  logic [127:0] data_from_mem;
  logic         read_ready_D;
  logic         written_data_ack_D;
  logic         busy;

  logic         reqI_1;
  logic [127:0] instr_1;
  logic         rdy_I_1;
  logic         ack_I_1;
  logic         reqD_1;
  logic [127:0] data_1;
  logic         rdy_D_1;
  logic         ack_D_1;
  logic         busy_1;

  int errors = 0;
  int checks = 0;
  exp_t exp_q[$];
  logic [127:0] model [int];

  localparam logic [127:0] LINE_10 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [127:0] LINE_3  = 128'hDEADBEEF_00000000_CAFEF00D_12345678;
  localparam logic [127:0] LINE_5A = 128'h5555_AAAA_5555_AAAA_1111_2222_3333_4444;
  localparam logic [127:0] LINE_5B = 128'hFFFF_0000_FFFF_0000_9999_8888_7777_6666;

  imem_dmem_arbiter #(.LATENCY(LAT), .DEPTH_LOG2(10)) dut (
    .clk(clk), .reset(reset),
    .reqI_mem(reqI_mem), .reqAddrI_mem(reqAddrI_mem),
    .instr_from_mem(instr_from_mem), .read_ready_I(read_ready_I),
    .written_data_ack_I(written_data_ack_I),
    .reqD_mem(reqD_mem), .reqD_write(reqD_write), .reqAddrD_mem(reqAddrD_mem),
    .reqD_wdata(reqD_wdata), .data_from_mem(data_from_mem),
    .read_ready_D(read_ready_D), .written_data_ack_D(written_data_ack_D),
    .busy(busy)
  );

  imem_dmem_arbiter #(.LATENCY(1), .DEPTH_LOG2(10)) dut_l1 (
    .clk(clk), .reset(reset),
    .reqI_mem(reqI_1), .reqAddrI_mem(26'h0000010),
    .instr_from_mem(instr_1), .read_ready_I(rdy_I_1),
    .written_data_ack_I(ack_I_1),
    .reqD_mem(reqD_1), .reqD_write(1'b0), .reqAddrD_mem(26'h0000020),
    .reqD_wdata(128'h0), .data_from_mem(data_1),
    .read_ready_D(rdy_D_1), .written_data_ack_D(ack_D_1),
    .busy(busy_1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic test_reset;
    reset = 1'b0;
    reqI_mem = 0; reqAddrI_mem = '0; reqD_mem = 0; reqD_write = 0;
    reqAddrD_mem = '0; reqD_wdata = '0; reqI_1 = 0; reqD_1 = 0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, read_ready_I, read_ready_D, written_data_ack_I, written_data_ack_D} !== 5'b0) begin
      errors++;
      $display("[TB] FAIL reset_ctrl: got %b expected 00000",
               {busy, read_ready_I, read_ready_D, written_data_ack_I, written_data_ack_D});
    end
    checks++;
    if ({instr_from_mem, data_from_mem} !== 256'h0) begin
      errors++;
      $display("[TB] FAIL reset_data: got %h/%h expected 0", instr_from_mem, data_from_mem);
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  // Drives one transaction from an IDLE-cycle negedge and checks its whole timeline.
  task automatic run_txn(input bit is_d, input bit wr, input logic [25:0] addr,
                         input logic [127:0] wdata);
    exp_t e;
    bit seen;
    logic pulse;
    logic [127:0] got;
    e.is_d = is_d;
    e.wr   = wr;
    e.data = wr ? 128'h0 : model[int'(addr[9:0])];
    if (wr) model[int'(addr[9:0])] = wdata;
    exp_q.push_back(e);
    if (is_d) begin
      reqD_mem = 1; reqD_write = wr; reqAddrD_mem = addr; reqD_wdata = wdata;
    end else begin
      reqI_mem = 1; reqAddrI_mem = addr;
    end
    seen = 0;
    got  = '0;
    for (int cyc = 1; cyc <= LAT + 4 && !seen; cyc++) begin
      @(negedge clk);
      checks++;
      if (written_data_ack_I !== (!is_d && cyc == 1)) begin
        errors++;
        $display("[TB] FAIL ack_I_timing cyc%0d: got %b expected %b", cyc,
                 written_data_ack_I, (!is_d && cyc == 1));
      end
      checks++;
      if (busy !== 1'b1) begin
        errors++;
        $display("[TB] FAIL busy cyc%0d: got %b expected 1", cyc, busy);
      end
      pulse = is_d ? (wr ? written_data_ack_D : read_ready_D) : read_ready_I;
      if (pulse === 1'b1) begin
        seen = 1;
        e = exp_q.pop_front();
        checks++;
        if (cyc != LAT + 1) begin
          errors++;
          $display("[TB] FAIL resp_cycle: got %0d expected %0d", cyc, LAT + 1);
        end
        if (!e.wr) begin
          got = e.is_d ? data_from_mem : instr_from_mem;
          checks++;
          if (got !== e.data) begin
            errors++;
            $display("[TB] FAIL read_data: got %h expected %h", got, e.data);
          end
        end
        reqI_mem = 0; reqD_mem = 0;
      end
    end
    if (!seen) begin
      checks++; errors++;
      $display("[TB] FAIL resp_timeout: got no pulse expected one by cycle %0d", LAT + 1);
      void'(exp_q.pop_front());
      reqI_mem = 0; reqD_mem = 0;
    end
    @(negedge clk);
    pulse = is_d ? (wr ? written_data_ack_D : read_ready_D) : read_ready_I;
    checks++;
    if ({pulse, busy} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL after_resp pulse/busy: got %b expected 00", {pulse, busy});
    end
    if (!wr) begin
      got = is_d ? data_from_mem : instr_from_mem;
      checks++;
      if (got !== e.data) begin
        errors++;
        $display("[TB] FAIL data_hold: got %h expected %h", got, e.data);
      end
    end
  endtask

  task automatic test_i_read;
    run_txn(1'b1, 1'b1, 26'h0000010, LINE_10);
    run_txn(1'b0, 1'b0, 26'h0000010, '0);
  endtask

  task automatic test_write_read;
    run_txn(1'b1, 1'b1, 26'h0000003, LINE_3);
    run_txn(1'b1, 1'b0, 26'h0000003, '0);
  endtask

  // Both requesters raised together; rsp_cyc lists when each response is due.
  task automatic test_contention;
    exp_t e;
    int n_resp;
    int rsp_cyc[4];
    bit exp_ack_i;
    logic [127:0] got;
`ifdef IMEM_DMEM_ARB_RR_EN
    bit order_d[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    int n_txn = 4;
`else
    bit order_d[4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    int n_txn = 2;
`endif
    for (int k = 0; k < n_txn; k++) begin
      e.is_d = order_d[k];
      e.wr   = 1'b0;
      e.data = order_d[k] ? model[3] : model[16];
      exp_q.push_back(e);
      rsp_cyc[k] = (k + 1) * (LAT + 2) - 1;
    end
    reqD_mem = 1; reqD_write = 0; reqAddrD_mem = 26'h0000003;
    reqI_mem = 1; reqAddrI_mem = 26'h0000010;
    n_resp = 0;
    for (int cyc = 1; cyc <= 40 && n_resp < n_txn; cyc++) begin
      @(negedge clk);
      exp_ack_i = 0;
      for (int k = 0; k < n_txn; k++)
        if (!order_d[k] && cyc == rsp_cyc[k] - LAT) exp_ack_i = 1;
      checks++;
      if (written_data_ack_I !== exp_ack_i) begin
        errors++;
        $display("[TB] FAIL contention_ack_I cyc%0d: got %b expected %b", cyc,
                 written_data_ack_I, exp_ack_i);
      end
      if (read_ready_I === 1'b1 || read_ready_D === 1'b1) begin
        e = exp_q.pop_front();
        checks++;
        if (read_ready_D !== e.is_d || cyc != rsp_cyc[n_resp]) begin
          errors++;
          $display("[TB] FAIL grant_order #%0d: got D=%b at cyc%0d expected D=%b at cyc%0d",
                   n_resp, read_ready_D, cyc, e.is_d, rsp_cyc[n_resp]);
        end
        got = read_ready_D ? data_from_mem : instr_from_mem;
        checks++;
        if (got !== e.data) begin
          errors++;
          $display("[TB] FAIL contention_data #%0d: got %h expected %h", n_resp, got, e.data);
        end
        n_resp++;
`ifndef IMEM_DMEM_ARB_RR_EN
        if (read_ready_D === 1'b1) reqD_mem = 0;
`endif
      end
    end
    reqI_mem = 0; reqD_mem = 0;
    if (n_resp < n_txn) begin
      checks++; errors++;
      $display("[TB] FAIL contention_timeout: got %0d responses expected %0d", n_resp, n_txn);
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic test_reset_abort;
    run_txn(1'b1, 1'b1, 26'h0000005, LINE_5A);
    reqD_mem = 1; reqD_write = 1; reqAddrD_mem = 26'h0000005; reqD_wdata = LINE_5B;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL abort_busy_before: got %b expected 1", busy);
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({busy, read_ready_I, read_ready_D, written_data_ack_I, written_data_ack_D} !== 5'b0 ||
        {instr_from_mem, data_from_mem} !== 256'h0) begin
      errors++;
      $display("[TB] FAIL abort_outputs: got ctrl=%b i=%h d=%h expected all 0",
               {busy, read_ready_I, read_ready_D, written_data_ack_I, written_data_ack_D},
               instr_from_mem, data_from_mem);
    end
    reqD_mem = 0; reqD_write = 0;
    repeat (4) begin
      @(negedge clk);
      checks++;
      if (written_data_ack_D !== 1'b0) begin
        errors++;
        $display("[TB] FAIL abort_no_ack: got %b expected 0", written_data_ack_D);
      end
    end
    reset = 1'b1;
    @(negedge clk);
    run_txn(1'b1, 1'b0, 26'h0000005, '0);
  endtask

  task automatic test_latency_one;
    bit exp_rdy_i, exp_rdy_d, exp_busy;
    reqI_1 = 1;
    for (int cyc = 1; cyc <= 6; cyc++) begin
      @(negedge clk);
      exp_busy  = (cyc == 1 || cyc == 2 || cyc == 4 || cyc == 5);
      exp_rdy_i = (cyc == 2);
      exp_rdy_d = (cyc == 5);
      checks++;
      if ({busy_1, rdy_I_1, ack_I_1, rdy_D_1} !== {exp_busy, exp_rdy_i, cyc == 1, exp_rdy_d}) begin
        errors++;
        $display("[TB] FAIL lat1 cyc%0d busy/rdyI/ackI/rdyD: got %b expected %b", cyc,
                 {busy_1, rdy_I_1, ack_I_1, rdy_D_1}, {exp_busy, exp_rdy_i, cyc == 1, exp_rdy_d});
      end
      if (cyc == 1) reqD_1 = 1;
      if (rdy_I_1 === 1'b1) reqI_1 = 0;
      if (rdy_D_1 === 1'b1) reqD_1 = 0;
    end
    reqI_1 = 0; reqD_1 = 0;
  endtask

  initial begin
    test_reset();
    test_i_read();
    test_write_read();
    test_contention();
    test_reset_abort();
    test_latency_one();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
